// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, FSM state type and byte-emit helper for
// the instruction writer.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] IFUN_MAX_OPQ  = 4'd3;
    localparam logic [3:0] IFUN_MAX_CC   = 4'd6;
    localparam logic [3:0] IFUN_MAX_NONE = 4'd0;

    localparam logic [3:0] LEN_BARE = 4'd1;   // icode/ifun only
    localparam logic [3:0] LEN_REG  = 4'd2;   // + register byte
    localparam logic [3:0] LEN_DEST = 4'd9;   // + 8-byte destination
    localparam logic [3:0] LEN_REGC = 4'd10;  // + register byte + 8-byte constant

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        ERR
    } state_t;

    typedef struct packed {
        logic [3:0]  len;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
    } emit_t;

    // Byte k (k >= 1) of a latched instruction; byte 0 is emitted at acceptance.
    function automatic logic [7:0] emit_byte(input emit_t f, input logic [3:0] k);
        logic [3:0] first_c;
        first_c = (f.len == LEN_REGC) ? 4'd2 : 4'd1;
        if (f.len != LEN_DEST && k == 4'd1)
            emit_byte = {f.ra, f.rb};
        else
            emit_byte = 8'(f.valc >> {k - first_c, 3'b000});
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational Y86 instruction length and ifun legality lookup.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic [3:0] len,
    output logic       legal
);

    logic [3:0] ifun_max;
    logic       known;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        len      = LEN_BARE;
        ifun_max = IFUN_MAX_NONE;
        known    = 1'b1;
        case (icode)
            IHALT, INOP, IRET:          len = LEN_BARE;
            IRRMOVQ: begin              len = LEN_REG;  ifun_max = IFUN_MAX_CC;  end
            IOPQ: begin                 len = LEN_REG;  ifun_max = IFUN_MAX_OPQ; end
            IPUSHQ, IPOPQ:              len = LEN_REG;
            IJXX: begin                 len = LEN_DEST; ifun_max = IFUN_MAX_CC;  end
            ICALL:                      len = LEN_DEST;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:  len = LEN_REGC;
            default:                    known = 1'b0;
        endcase
        legal = known && (ifun <= ifun_max);
    end

endmodule

// File: rtl/y86_instr_writer.sv
// Serialises Y86 instruction fields into one byte write per cycle into
// instruction memory, tracking the write pointer and a sticky error.
module y86_instr_writer
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_ifun,
    input  logic [3:0]  in_rA,
    input  logic [3:0]  in_rB,
    input  logic [63:0] in_valC,
    input  logic        addr_load,
    input  logic [63:0] addr_in,
    input  logic        err_clr,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [63:0] wr_ptr,
    output logic        err,
    output logic [15:0] instr_count
);

    state_t      state_q, state_d;
    logic [63:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] cnt_q, cnt_d;
    emit_t       fld_q, fld_d;
    logic [3:0]  idx_q, idx_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic [3:0]  len;
    logic        legal;
    logic [64:0] end_addr;
    logic        overflow;

    y86_instr_len u_len (
        .icode (in_icode),
        .ifun  (in_ifun),
        .len   (len),
        .legal (legal)
    );

    // One bit wider than the pointer so a wrap past 2^64 still reads as overflow.
    assign end_addr = {1'b0, wr_ptr_q} + {61'd0, len};
    assign overflow = end_addr > 65'(MEM_BYTES);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        fld_d       = fld_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (addr_load) begin
                    wr_ptr_d = addr_in;
                end else if (in_valid) begin
                    if (!legal || overflow) begin
                        state_d = ERR;
                    end else begin
                        state_d     = EMIT;
                        fld_d       = '{len: len, ra: in_rA, rb: in_rB, valc: in_valC};
                        idx_d       = 4'd1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_ptr_q;
                        mem_wdata_d = {in_icode, in_ifun};
                    end
                end
            end
            EMIT: begin
                if (idx_q == fld_q.len) begin
                    state_d  = IDLE;
                    wr_ptr_d = wr_ptr_q + {60'd0, fld_q.len};
                    cnt_d    = cnt_q + 16'd1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q + {60'd0, idx_q};
                    mem_wdata_d = emit_byte(fld_q, idx_q);
                    idx_d       = idx_q + 4'd1;
                end
            end
            ERR: begin
                if (err_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            fld_q       <= '0;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            fld_q       <= fld_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !addr_load;
    assign err         = (state_q == ERR);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr_ptr      = wr_ptr_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_y86_instr_writer.sv
// Scoreboard bench for y86_instr_writer: a table-driven encoder model queues
// expected byte writes, and a negedge monitor pops and compares them.
module tb_y86_instr_writer;

    localparam int unsigned MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_icode = '0, in_ifun = '0, in_rA = '0, in_rB = '0;
    logic [63:0] in_valC = '0;
    logic        addr_load = 1'b0;
    logic [63:0] addr_in = '0;
    logic        err_clr = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [63:0] wr_ptr;
    logic        err;
    logic [15:0] instr_count;

    y86_instr_writer #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_icode    (in_icode),
        .in_ifun     (in_ifun),
        .in_rA       (in_rA),
        .in_rB       (in_rB),
        .in_valC     (in_valC),
        .addr_load   (addr_load),
        .addr_in     (addr_in),
        .err_clr     (err_clr),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .wr_ptr      (wr_ptr),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] m_ptr = '0;
    logic [15:0] m_cnt = '0;
    time         acc_time;

    // Encoded length per icode (0 = undefined icode) and highest legal ifun.
    int len_tab[16]  = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
    int ifun_max[16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            check("ready_low_in_emit", {63'd0, in_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", {56'd0, mem_wdata}, {56'd0, e.data});
            end
        end
    end

    task automatic load_addr(input logic [63:0] a);
        @(negedge clk);
        addr_load = 1'b1;
        addr_in   = a;
        #1 check("ready_masked_by_load", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 addr_load = 1'b0;
        m_ptr = a;
        check("wr_ptr_after_load", wr_ptr, a);
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input bit keep,
                         output bit bad);
        logic [7:0] b[$];
        int len;
        int n;
        @(negedge clk);
        in_icode = ic; in_ifun = ifn; in_rA = ra; in_rB = rb; in_valC = vc;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 64'd1, 64'd0);
        len = len_tab[ic];
        bad = (len == 0) || (int'(ifn) > ifun_max[ic]) || (m_ptr + 64'(len) > 64'(MEM_BYTES));
        if (!bad) begin
            b.push_back({ic, ifn});
            if (len == 2 || len == 10) b.push_back({ra, rb});
            if (len >= 9) for (int i = 0; i < 8; i++) b.push_back(vc[8*i +: 8]);
            for (int k = 0; k < len; k++) exp_q.push_back('{m_ptr + 64'(k), b[k]});
            m_ptr = m_ptr + 64'(len);
            m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        acc_time = $time;
        #1;
        if (!keep || bad) in_valid = 1'b0;
        if (bad) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("err_set", {63'd0, err}, 64'd1);
                check("ready_low_in_err", {63'd0, in_ready}, 64'd0);
            end
            check("wr_ptr_kept_on_err", wr_ptr, m_ptr);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 64'd1, 64'd0);
        check("wr_ptr", wr_ptr, m_ptr);
        check("instr_count", {48'd0, instr_count}, {48'd0, m_cnt});
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", {63'd0, err}, 64'd0);
        check("ready_after_clr", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   bad;
        time  t1;
        logic [3:0] ic, ifn;

        #12;
        check("rst_wr_ptr", wr_ptr, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_count", {48'd0, instr_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_ready", {63'd0, in_ready}, 64'd1);

        // irmovq at 0x10
        load_addr(64'h10);
        issue(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123_4567_89AB_CDEF, 1'b0, bad);
        wait_done();

        // jmp at 0
        load_addr(64'h0);
        issue(4'h7, 4'h0, 4'h0, 4'h0, 64'h100, 1'b0, bad);
        wait_done();

        // back-to-back addq then halt with in_valid held high
        load_addr(64'h0);
        issue(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 1'b1, bad);
        t1 = acc_time;
        issue(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, bad);
        check("throughput_len_plus_1", 64'(acc_time - t1), 64'd30);
        wait_done();

        // err_clr outside ERR does nothing
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("err_clr_idle_noop", {63'd0, err}, 64'd0);

        // encode errors
        issue(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, bad);
        check("bad_icode_flagged", {63'd0, bad}, 64'd1);
        clear_err();
        issue(4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 1'b0, bad);
        check("bad_ifun_flagged", {63'd0, bad}, 64'd1);
        clear_err();

        // overflow, addr_load ignored in ERR, then last-byte nop
        load_addr(64'd1020);
        issue(4'h3, 4'h0, 4'hF, 4'h2, 64'h1122_3344_5566_7788, 1'b0, bad);
        @(negedge clk);
        addr_load = 1'b1;
        addr_in   = 64'h55;
        @(posedge clk);
        #1 addr_load = 1'b0;
        check("addr_load_ignored_in_err", wr_ptr, 64'd1020);
        clear_err();
        load_addr(64'd1023);
        issue(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, bad);
        wait_done();

        // randomized traffic
        load_addr(64'($urandom_range(0, 900)));
        for (int i = 0; i < 60; i++) begin
            bit keep;
            ic  = 4'($urandom_range(0, 13));
            if ($urandom_range(0, 3) == 0) ifn = 4'($urandom_range(0, 15));
            else                           ifn = 4'($urandom_range(0, ifun_max[ic]));
            keep = (i < 59) && ($urandom_range(0, 1) == 1);
            issue(ic, ifn, 4'($urandom), 4'($urandom), {$urandom, $urandom}, keep, bad);
            if (bad) begin
                clear_err();
                if (m_ptr > 64'd1000) load_addr(64'($urandom_range(0, 900)));
            end else if (!keep) begin
                wait_done();
            end
        end
        wait_done();

        // asynchronous reset while byte 4 of irmovq is on the bus
        load_addr(64'h200);
        issue(4'h3, 4'h0, 4'h4, 4'h5, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, bad);
        repeat (4) @(posedge clk);
        #2;
        check("byte4_we", {63'd0, mem_we}, 64'd1);
        check("byte4_addr", mem_addr, 64'h204);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", {63'd0, mem_we}, 64'd0);
        check("async_rst_addr", mem_addr, 64'd0);
        check("async_rst_wdata", {56'd0, mem_wdata}, 64'd0);
        check("async_rst_wr_ptr", wr_ptr, 64'd0);
        check("async_rst_count", {48'd0, instr_count}, 64'd0);
        check("async_rst_err", {63'd0, err}, 64'd0);
        exp_q.delete();
        m_ptr = '0;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 1'b0, bad);
        wait_done();

        repeat (3) @(negedge clk);
        check("leftover_writes", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/y86_instr_writer.md
Y86_INSTR_WRITER -- requirements
Module: y86_instr_writer

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the instruction memory size in bytes; legal addresses are 0..MEM_BYTES-1.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  instruction fields are presented.
REQ-006 in_ready  output  1  writer accepts; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 in_icode, in_ifun, in_rA, in_rB  input  4 each  Y86 instruction fields.
REQ-008 in_valC  input  64  constant or destination word.
REQ-009 addr_load  input  1  single-cycle pulse; loads the write pointer from addr_in.
REQ-010 addr_in  input  64  new write-pointer value.
REQ-011 err_clr  input  1  single-cycle pulse; clears the sticky error.
REQ-012 mem_we, mem_addr, mem_wdata  output  1/64/8  one byte write per cycle to instruction memory.
REQ-013 wr_ptr  output  64  address of the next instruction byte, equal to valP of the last written instruction.
REQ-014 err  output  1  sticky encode or overflow error.
REQ-015 instr_count  output  16  number of completed instructions; wraps at 0xFFFF.

Function
REQ-016 SHALL implement FSM states IDLE, EMIT and ERR.
REQ-017 in_ready SHALL equal (state==IDLE) && !addr_load.
REQ-018 In IDLE, addr_load SHALL set wr_ptr=addr_in and take priority over in_valid; in other states addr_load SHALL be ignored.
REQ-019 Length by icode: 0/1/9 -> 1 byte; 2/6/A/B -> 2; 7/8 -> 9; 3/4/5 -> 10.
REQ-020 Legal ifun values: icode 6 -> 0..3; icode 2/7 -> 0..6; every other icode -> 0.
REQ-021 An icode >= 0xC or an illegal ifun SHALL move to ERR with no write.
REQ-022 On acceptance, if wr_ptr+len > MEM_BYTES, SHALL move to ERR with no write and wr_ptr unchanged.
REQ-023 Otherwise SHALL latch the fields, enter EMIT, and write byte k (k=0..len-1) at wr_ptr+k in cycle t+1+k after acceptance at edge t.
REQ-024 Byte 0 = {icode,ifun}.
REQ-025 For 2- and 10-byte forms, byte 1 = {rA,rB}.
REQ-026 10-byte forms: bytes 2..9 = valC, little-endian (LSB first).
REQ-027 9-byte forms: bytes 1..8 = valC, little-endian.
REQ-028 mem_we SHALL be 1 exactly during the len EMIT cycles, with mem_addr/mem_wdata registered.
REQ-029 On the cycle after the last byte: wr_ptr += len, instr_count += 1, return to IDLE.
REQ-030 Throughput SHALL be one instruction per len+1 cycles.
REQ-031 In ERR: err=1, in_ready=0, no writes; err_clr SHALL clear err and return to IDLE.
REQ-032 err_clr outside ERR SHALL have no effect.
REQ-033 Inputs other than the handshake are don't-care while in_ready=0.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, wr_ptr=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, instr_count=0.
REQ-035 Reset during EMIT SHALL abort the instruction; bytes already written remain in memory and are not counted.

Structure
REQ-036 Shared package y86_pkg SHALL hold the icode constants (IHALT..IPOPQ), the ifun limits, the length constants and the FSM state enum.
REQ-037 The length/legality lookup SHALL be the combinational sub-module y86_instr_len (inputs: icode, ifun; outputs: len, legal).

Verification
REQ-038 Reset, addr_load 0x10, then irmovq (3,0,F,2,valC=0x0123456789ABCDEF) -> writes 0x10..0x19 = 30 F2 EF CD AB 89 67 45 23 01; wr_ptr=0x1A; instr_count=1.
REQ-039 At addr 0, jmp (7,0,valC=0x100) -> writes 0..8 = 70 00 01 00 00 00 00 00 00; wr_ptr=9.
REQ-040 in_valid held high with addq (6,0,0,3), then halt -> bytes 60 03 then 00; in_ready low during each EMIT; wr_ptr=3.
REQ-041 icode 0xC, or icode 6 with ifun 5 -> err=1, no mem_we, in_ready=0 until err_clr; wr_ptr unchanged.
REQ-042 wr_ptr=1020 with irmovq -> overflow err, no writes; after err_clr, addr_load 1023 and nop -> single write 10 at 1023, wr_ptr=1024.
REQ-043 rst_n low asynchronously while byte 4 of irmovq is being written -> mem_we=0 and all outputs at reset values before the next edge; instr_count=0.
